// File: rtl/seq_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_pkg
// Description : Shared types and helpers for the iterative multiplier.
//               - stateType : controller states (IDLE, RUN, FIX)
//               - MODE_*    : operand signedness encodings
//               - cntWidth  : width of the iteration counter
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } stateType;

    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_SU = 2'b01;
    localparam logic [1:0] MODE_SS = 2'b11;

    // Counter must hold the value WIDTH/DIGIT itself, hence the +1.
    function automatic int cntWidth(input int width, input int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_digit_pp.sv
`default_nettype none
// ============================================================================
// Module      : mul_digit_pp
// Description : Combinational unsigned WIDTH x DIGIT partial-product generator.
// Ports       : multiplicand   in  WIDTH        unsigned multiplicand
//               digit          in  DIGIT        multiplier digit
//               partialProduct out WIDTH+DIGIT  multiplicand * digit
// Revision    : 1.0 - initial release
// ============================================================================
module mul_digit_pp
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [DIGIT-1:0]       digit,
    output logic [WIDTH+DIGIT-1:0] partialProduct
);

    // Both operands are widened to the result width; the true product
    // never exceeds WIDTH+DIGIT bits so nothing is lost in truncation.
    always_comb begin
        partialProduct = {{DIGIT{1'b0}}, multiplicand} * {{WIDTH{1'b0}}, digit};
    end

endmodule
`default_nettype wire

// File: rtl/seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul
// Description : Iterative multiplier retiring DIGIT multiplier bits per cycle,
//               producing the full 2*WIDTH-bit product with signed/unsigned
//               operand modes and a start/busy/done handshake.
// Ports       : clk       in  1      clock, rising edge
//               rst_n     in  1      asynchronous active-low reset
//               start     in  1      launch request (sampled in IDLE only)
//               mode      in  2      00 UxU, 01 SxU, 11 SxS, 10 as 00
//               a         in  WIDTH  multiplicand
//               b         in  WIDTH  multiplier
//               busy      out 1      operation in progress
//               done      out 1      one-cycle pulse when result is written
//               res_high  out WIDTH  upper half of product
//               res_low   out WIDTH  lower half of product
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_high,
    output logic [WIDTH-1:0] res_low
);

    localparam int                c_numIter = WIDTH / DIGIT;
    localparam int                c_cntW    = cntWidth(WIDTH, DIGIT);
    localparam logic [c_cntW-1:0] c_cntLoad = c_cntW'(c_numIter);

    if (!((DIGIT == 1) || (DIGIT == 2) || (DIGIT == 4)) ||
        ((WIDTH % DIGIT) != 0) || (WIDTH < 4)) begin : g_badParams
        $error("seq_mul: DIGIT must be 1, 2 or 4 and divide WIDTH (WIDTH >= 4)");
    end

    stateType               r_state;
    stateType               w_nextState;
    logic [WIDTH-1:0]       r_aMag;
    logic [WIDTH-1:0]       r_bWork;
    logic                   r_neg;
    logic [2*WIDTH-1:0]     r_acc;
    logic [c_cntW-1:0]      r_cnt;
    logic [WIDTH-1:0]       r_resHigh;
    logic [WIDTH-1:0]       r_resLow;
    logic                   r_done;

    logic                   w_aNeg;
    logic                   w_bNeg;
    logic [WIDTH-1:0]       w_aMag;
    logic [WIDTH-1:0]       w_bMag;
    logic [WIDTH+DIGIT-1:0] w_pp;
    logic [WIDTH+DIGIT-1:0] w_sum;
    logic [2*WIDTH+DIGIT-1:0] w_accShift;
    logic [2*WIDTH-1:0]     w_accNext;
    logic [2*WIDTH-1:0]     w_product;
    logic                   w_lastIter;

    // Operand conditioning: mode 10 decodes as unsigned on both sides.
    assign w_aNeg = ((mode == MODE_SU) || (mode == MODE_SS)) && a[WIDTH-1];
    assign w_bNeg = (mode == MODE_SS) && b[WIDTH-1];
    assign w_aMag = w_aNeg ? (~a + 1'b1) : a;
    assign w_bMag = w_bNeg ? (~b + 1'b1) : b;

    mul_digit_pp #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_pp (
        .multiplicand   (r_aMag),
        .digit          (r_bWork[DIGIT-1:0]),
        .partialProduct (w_pp)
    );

    // Shift-right accumulation: the partial product is added into the upper
    // half and the whole accumulator moves down by DIGIT each iteration, so
    // after N iterations every digit has landed at its proper weight. The
    // sum of the upper half and a partial product always fits WIDTH+DIGIT bits.
    assign w_sum      = {{DIGIT{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_pp;
    assign w_accShift = {w_sum, r_acc[WIDTH-1:0]};
    assign w_accNext  = w_accShift[2*WIDTH+DIGIT-1:DIGIT];

    assign w_product  = r_neg ? (~r_acc + 1'b1) : r_acc;
    assign w_lastIter = (r_cnt == c_cntW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastIter) begin
                    w_nextState = FIX;
                end
            end
            FIX: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
                busy        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aMag    <= '0;
            r_bWork   <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_resHigh <= '0;
            r_resLow  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_aMag  <= w_aMag;
                        r_bWork <= w_bMag;
                        r_neg   <= w_aNeg ^ w_bNeg;
                        r_acc   <= '0;
                        r_cnt   <= c_cntLoad;
                    end
                end
                RUN: begin
                    r_acc   <= w_accNext;
                    r_bWork <= r_bWork >> DIGIT;
                    r_cnt   <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_resHigh <= w_product[2*WIDTH-1:WIDTH];
                    r_resLow  <= w_product[WIDTH-1:0];
                    r_done    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign done     = r_done;
    assign res_high = r_resHigh;
    assign res_low  = r_resLow;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mul
// Description : Self-checking bench for seq_mul (DIGIT=2 main instance, plus
//               DIGIT=1 and DIGIT=4 instances for latency/result checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mul;

    localparam int W     = 32;
    localparam int NITER = W / 2;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start2 = 1'b0;
    logic start1 = 1'b0;
    logic start4 = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] a    = '0;
    logic [W-1:0] b    = '0;

    logic busy2, done2, busy1, done1, busy4, done4;
    logic [W-1:0] hi2, lo2, hi1, lo1, hi4, lo4;

    int nChecks = 0;
    int nFail   = 0;
    bit cmpEn   = 1'b0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(W), .DIGIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .a(a), .b(b),
        .busy(busy2), .done(done2), .res_high(hi2), .res_low(lo2));
    seq_mul #(.WIDTH(W), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .a(a), .b(b),
        .busy(busy1), .done(done1), .res_high(hi1), .res_low(lo1));
    seq_mul #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .a(a), .b(b),
        .busy(busy4), .done(done4), .res_high(hi4), .res_low(lo4));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product by plain 64-bit arithmetic on sign/zero-extended values.
    function automatic logic [63:0] refMul(input logic [1:0] m, input logic [31:0] x,
                                           input logic [31:0] y);
        longint xv;
        longint yv;
        xv = m[0] ? longint'($signed(x)) : longint'({32'd0, x});
        yv = (m == 2'b11) ? longint'($signed(y)) : longint'({32'd0, y});
        return 64'(xv * yv);
    endfunction

    // ---------------- behavioural model of the DIGIT=2 instance -------------
    int          mLeft = 0;   // edges remaining until the result is written
    logic [63:0] mPend = '0;
    logic [31:0] mHi   = '0;
    logic [31:0] mLo   = '0;
    bit          mDone = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mLeft <= 0;
            mHi   <= '0;
            mLo   <= '0;
            mDone <= 1'b0;
        end else begin
            mDone <= 1'b0;
            if (mLeft == 0) begin
                if (start2) begin
                    mLeft <= NITER + 1;
                    mPend <= refMul(mode, a, b);
                end
            end else begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    mHi   <= mPend[63:32];
                    mLo   <= mPend[31:0];
                    mDone <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            check("cyc_busy", 64'(busy2), 64'(mLeft != 0));
            check("cyc_done", 64'(done2), 64'(mDone));
            check("cyc_hi",   64'(hi2),   64'(mHi));
            check("cyc_lo",   64'(lo2),   64'(mLo));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic setStart(input int sel, input logic v);
        case (sel)
            1:       start1 = v;
            4:       start4 = v;
            default: start2 = v;
        endcase
    endtask

    function automatic logic [2:0] statOf(input int sel);
        case (sel)
            1:       return {done1, busy1, 1'b0};
            4:       return {done4, busy4, 1'b0};
            default: return {done2, busy2, 1'b0};
        endcase
    endfunction

    function automatic logic [63:0] resOf(input int sel);
        case (sel)
            1:       return {hi1, lo1};
            4:       return {hi4, lo4};
            default: return {hi2, lo2};
        endcase
    endfunction

    task automatic launch(input int sel, input logic [1:0] m, input logic [31:0] x,
                          input logic [31:0] y);
        mode = m;
        a    = x;
        b    = y;
        setStart(sel, 1'b1);
    endtask

    // Called right after launch; returns in the done cycle.
    task automatic waitOp(input int sel, input logic [63:0] expRes, input int expLat,
                          input string name, input bit randStart);
        bit         got   = 1'b0;
        int         busyN = 0;
        int         lat   = -1;
        logic [2:0] st;
        for (int i = 1; i <= 200 && !got; i++) begin
            @(negedge clk);
            st = statOf(sel);
            if (st[1]) busyN++;
            if (st[2]) begin
                got = 1'b1;
                lat = i - 1;
            end else if (randStart && i >= 2 && i < expLat) begin
                setStart(sel, 1'($urandom_range(0, 1)));
                a    = $urandom;
                b    = $urandom;
                mode = 2'($urandom);
            end else begin
                setStart(sel, 1'b0);
            end
        end
        check({name, "_doneSeen"}, 64'(got), 64'd1);
        check({name, "_latency"}, 64'(lat), 64'(expLat));
        check({name, "_busyCycles"}, 64'(busyN), 64'(expLat));
        check({name, "_result"}, resOf(sel), expRes);
    endtask

    task automatic runOp(input int sel, input logic [1:0] m, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] expRes, input int expLat,
                         input string name, input bit randStart);
        @(negedge clk);
        launch(sel, m, x, y);
        waitOp(sel, expRes, expLat, name, randStart);
    endtask

    task automatic waitDone2(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            setStart(2, 1'b0);
            got = done2;
        end
        check({name, "_doneSeen"}, 64'(got), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy2), 64'd0);
        check("rst_done", 64'(done2), 64'd0);
        check("rst_res2", {hi2, lo2}, 64'd0);
        check("rst_res1", {hi1, lo1}, 64'd0);
        check("rst_res4", {hi4, lo4}, 64'd0);
        rst_n = 1'b1;
        cmpEn = 1'b1;

        runOp(2, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 17, "uuMax", 1'b0);
        runOp(2, 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 17, "ssSmall", 1'b0);
        runOp(2, 2'b11, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 17, "ssMin", 1'b0);
        runOp(2, 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 17, "suMix", 1'b0);
        runOp(2, 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 17, "mode10", 1'b0);

        // start held mid-run with different operands must be ignored
        @(negedge clk);
        launch(2, 2'b00, 32'h0000_1234, 32'h0000_5678);
        repeat (3) begin
            @(negedge clk);
            setStart(2, 1'b0);
        end
        a      = 32'hDEAD_BEEF;
        b      = 32'hCAFE_F00D;
        mode   = 2'b11;
        start2 = 1'b1;
        repeat (5) @(negedge clk);
        start2 = 1'b0;
        waitDone2("holdStart");
        check("holdStart_result", {hi2, lo2}, 64'h0000_0000_0626_0060);

        // back-to-back: launch in the done cycle
        launch(2, 2'b00, 32'hFFFF_FFFF, 32'h0000_0010);
        @(negedge clk);
        setStart(2, 1'b0);
        check("b2b_accepted", 64'(busy2), 64'd1);
        check("b2b_doneFell", 64'(done2), 64'd0);
        check("b2b_resHeld", {hi2, lo2}, 64'h0000_0000_0626_0060);
        waitDone2("b2b");
        check("b2b_result", {hi2, lo2}, 64'h0000_000F_FFFF_FFF0);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        launch(2, 2'b00, 32'h0001_0000, 32'h0001_0000);
        repeat (6) begin
            @(negedge clk);
            setStart(2, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midRst_busy", 64'(busy2), 64'd0);
        check("midRst_done", 64'(done2), 64'd0);
        check("midRst_res", {hi2, lo2}, 64'd0);
        #1 rst_n = 1'b1;
        runOp(2, 2'b00, 32'd7, 32'd6, 64'd42, 17, "afterRst", 1'b0);

        // other digit sizes
        runOp(1, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 33, "digit1", 1'b0);
        runOp(4, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 9, "digit4", 1'b0);
        runOp(4, 2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 9, "digit4ss", 1'b0);

        // randomized operations, with start/operand noise while busy
        for (int t = 0; t < 40; t++) begin
            logic [1:0]  m;
            logic [31:0] x;
            logic [31:0] y;
            m = 2'($urandom);
            x = pick();
            y = pick();
            if ($urandom_range(0, 2) == 0) begin
                launch(2, m, x, y);           // straight out of the done cycle
            end else begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                launch(2, m, x, y);
            end
            waitOp(2, refMul(m, x, y), 17, "rand", 1'b1);
        end

        @(negedge clk);
        setStart(2, 1'b0);
        repeat (2) @(negedge clk);
        cmpEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
